icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: INDEX_WIDTH, default 4, log2 of entry count (16 entries, index = PC[4:1]).
REQ-002 Parameter: TAG_WIDTH, default 27, tag = PC[31:5].
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst_in  input  1  synchronous, active-high reset.
REQ-005 rdy_in  input  1  global enable; low = all state held.
REQ-006 flush  input  1  pipeline flush (mispredict); aborts outstanding fetch.
REQ-007 if2cache_en  input  1  ifetch request valid.
REQ-008 if2cache_PC  input  32  requested fetch address, halfword aligned.
REQ-009 cache2if_ready  output  1  cache can accept a request this cycle.
REQ-010 cache2if_valid  output  1  one-cycle pulse: instruction returned.
REQ-011 cache2if_inst  output  32  returned instruction word.
REQ-012 cache2if_PC  output  32  address of returned instruction.
REQ-013 cache2mem_upd_en  output  1  fill request to memory controller, level.
REQ-014 cache2mem_PC  output  32  fill address, stable while upd_en high.
REQ-015 mem2cache_upd  input  1  one-cycle fill-complete pulse.
REQ-016 mem2cache_idx / mem2cache_tag  input  INDEX_WIDTH / TAG_WIDTH  entry to write.
REQ-017 mem2if_inst_out  input  32  fill data, valid with mem2cache_upd.
REQ-018 mem2cache_PC  input  32  fill address, valid with mem2cache_upd.

Function
REQ-019 Storage SHALL be direct-mapped: per entry valid bit, TAG_WIDTH tag, 32-bit data; one instruction word per entry.
REQ-020 States SHALL be IDLE, MISS, RESP.
REQ-021 cache2if_ready SHALL equal (state==IDLE) && !flush && rdy_in.
REQ-022 IDLE, if2cache_en && ready, hit (valid[PC[4:1]] && tag match PC[31:5]): next cycle cache2if_valid=1, inst=stored data, PC=request PC; state stays IDLE (hit latency 1 cycle, back-to-back hits allowed).
REQ-023 IDLE, request misses: latch PC, go MISS; from next cycle cache2mem_upd_en=1, cache2mem_PC=latched PC, held until fill.
REQ-024 MISS, mem2cache_upd=1: write entry [mem2cache_idx] with tag, data=mem2if_inst_out, valid=1; deassert upd_en same edge; go RESP.
REQ-025 RESP: cache2if_valid=1 for exactly one cycle with filled word and latched PC; return to IDLE.
REQ-026 Requests in MISS or RESP SHALL be ignored (ready=0); ifetch holds request.
REQ-027 mem2cache_upd outside MISS SHALL still write the entry but produce no cache2if_valid.
REQ-028 flush in any state: state->IDLE, upd_en=0 next cycle, pending response dropped, no cache2if_valid next cycle; entries retained.
REQ-029 flush coincident with mem2cache_upd: entry written, no response, state IDLE.
REQ-030 flush coincident with a request: request not accepted.
REQ-031 Hit and fill to same index in same cycle (IDLE): lookup uses pre-write contents.
REQ-032 rdy_in=0: no state, entry, or output register changes; valid pulses extended until rdy_in returns.
REQ-033 Outputs registered; cache2if_inst/PC SHALL be 0 when cache2if_valid=0.

Reset
REQ-034 rst_in=1 at posedge: all valid bits cleared, state IDLE, cache2if_valid=0, cache2if_inst=0, cache2if_PC=0, cache2mem_upd_en=0, cache2mem_PC=0.
REQ-035 Reset mid-MISS SHALL abandon fill; a later mem2cache_upd in IDLE follows REQ-027.
REQ-036 rst_in overrides flush and rdy_in.

Verification
REQ-037 Cold miss: reset, request PC=0x0000_0000 -> upd_en=1, cache2mem_PC=0; fill pulse data 0x0000_0513 -> next cycle valid=1, inst=0x0000_0513, PC=0.
REQ-038 Hit after fill: re-request PC=0 -> valid exactly 1 cycle later, inst=0x0000_0513, no upd_en.
REQ-039 Conflict: fill PC=0x04, then request PC=0x24 (same idx 2, tag 1) -> miss, upd_en with PC=0x24; after fill, PC=0x04 misses again.
REQ-040 Flush in MISS: request PC=0x100 miss, flush two cycles later -> upd_en=0 next cycle, no valid pulse, ready=1 next cycle; late fill writes idx 0, no valid.
REQ-041 Stall: rdy_in=0 during RESP for 3 cycles -> valid held, inst/PC unchanged, single accepted response after rdy_in=1.
REQ-042 Reset mid-MISS: rst_in during MISS -> all outputs 0, PC=0 lookup misses.

Source files
------------

// File: rtl/icache_if.sv
// Instruction-cache bus bundle: ifetch request/response plus memory-fill channel.
// slave  : the cache side (takes requests and fills, returns instructions).
// master : the ifetch/memory side (issues requests and fills).
interface icache_if #(
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned TAG_WIDTH   = 27
);
  logic                   if2cache_en;
  logic [31:0]            if2cache_PC;
  logic                   cache2if_ready;
  logic                   cache2if_valid;
  logic [31:0]            cache2if_inst;
  logic [31:0]            cache2if_PC;
  logic                   cache2mem_upd_en;
  logic [31:0]            cache2mem_PC;
  logic                   mem2cache_upd;
  logic [INDEX_WIDTH-1:0] mem2cache_idx;
  logic [TAG_WIDTH-1:0]   mem2cache_tag;
  logic [31:0]            mem2if_inst_out;
  logic [31:0]            mem2cache_PC;

  modport slave (
    input  if2cache_en, if2cache_PC,
    input  mem2cache_upd, mem2cache_idx, mem2cache_tag, mem2if_inst_out, mem2cache_PC,
    output cache2if_ready, cache2if_valid, cache2if_inst, cache2if_PC,
    output cache2mem_upd_en, cache2mem_PC
  );

  modport master (
    output if2cache_en, if2cache_PC,
    output mem2cache_upd, mem2cache_idx, mem2cache_tag, mem2if_inst_out, mem2cache_PC,
    input  cache2if_ready, cache2if_valid, cache2if_inst, cache2if_PC,
    input  cache2mem_upd_en, cache2mem_PC
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per entry.
// Ports:
//   clk     - sole clock, all updates on posedge
//   rst_in  - synchronous active-high reset (overrides flush and rdy_in)
//   rdy_in  - global enable; low holds every register and entry
//   flush   - aborts any outstanding fetch; entries are kept
//   bus     - icache_if.slave: ifetch request/response and memory fill channel
// Hits return one cycle after acceptance; a miss raises cache2mem_upd_en until
// the fill pulse, then presents the filled word for one cycle.
module icache #(
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned TAG_WIDTH   = 27
) (
  input  logic      clk,
  input  logic      rst_in,
  input  logic      rdy_in,
  input  logic      flush,
  icache_if.slave   bus
);

  localparam int unsigned ENTRIES = 32'(1) << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

  state_t                 state;
  logic [ENTRIES-1:0]     valid_bits;
  logic [TAG_WIDTH-1:0]   tag_mem  [ENTRIES];
  logic [31:0]            data_mem [ENTRIES];

  logic [INDEX_WIDTH-1:0] req_idx;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   hit;
  logic                   fill_we;
  logic                   unused_inputs;

  // Lookup reads the arrays before this edge's fill lands (pre-write contents).
  assign req_idx = bus.if2cache_PC[INDEX_WIDTH:1];
  assign req_tag = bus.if2cache_PC[31 -: TAG_WIDTH];
  assign hit     = valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);

  assign bus.cache2if_ready = (state == IDLE) && !flush && rdy_in;

  // A fill always writes its entry, whatever the state or flush.
  assign fill_we = !rst_in && rdy_in && bus.mem2cache_upd;

  // Halfword bit and the echoed fill address carry no information here.
  assign unused_inputs = ^{bus.if2cache_PC[0], bus.mem2cache_PC};

  // Tag/data arrays: no reset needed, valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[bus.mem2cache_idx]  <= bus.mem2cache_tag;
      data_mem[bus.mem2cache_idx] <= bus.mem2if_inst_out;
    end
  end

  // Control FSM with registered outputs; cache2mem_PC doubles as the latched miss PC.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state                <= IDLE;
      valid_bits           <= '0;
      bus.cache2if_valid   <= 1'b0;
      bus.cache2if_inst    <= '0;
      bus.cache2if_PC      <= '0;
      bus.cache2mem_upd_en <= 1'b0;
      bus.cache2mem_PC     <= '0;
    end else if (rdy_in) begin
      if (bus.mem2cache_upd) begin
        valid_bits[bus.mem2cache_idx] <= 1'b1;
      end
      bus.cache2if_valid <= 1'b0;
      bus.cache2if_inst  <= '0;
      bus.cache2if_PC    <= '0;
      if (flush) begin
        state                <= IDLE;
        bus.cache2mem_upd_en <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.if2cache_en) begin
              if (hit) begin
                bus.cache2if_valid <= 1'b1;
                bus.cache2if_inst  <= data_mem[req_idx];
                bus.cache2if_PC    <= bus.if2cache_PC;
              end else begin
                state                <= MISS;
                bus.cache2mem_upd_en <= 1'b1;
                bus.cache2mem_PC     <= bus.if2cache_PC;
              end
            end
          end
          MISS: begin
            if (bus.mem2cache_upd) begin
              state                <= RESP;
              bus.cache2mem_upd_en <= 1'b0;
              bus.cache2if_valid   <= 1'b1;
              bus.cache2if_inst    <= bus.mem2if_inst_out;
              bus.cache2if_PC      <= bus.cache2mem_PC;
            end
          end
          RESP: begin
            // Response is visible during RESP; leaving clears it.
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed vector table, hand-written multi-cycle sequences,
// and a randomized run against a word-level reference model.
module tb_icache;

  logic clk = 1'b0;
  logic rst_in, rdy_in, flush;

  icache_if #(.INDEX_WIDTH(4), .TAG_WIDTH(27)) bus ();

  icache #(.INDEX_WIDTH(4), .TAG_WIDTH(27)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        en;
    logic [31:0] pc;
    logic        upd;
    logic [31:0] fill_pc;
    logic [31:0] data;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    logic        exp_upd;
    logic [31:0] exp_mem_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic en, logic [31:0] pc, logic upd, logic [31:0] fpc,
                              logic [31:0] d, logic rdy_e, logic v, logic [31:0] inst,
                              logic [31:0] vpc, logic u, logic [31:0] mpc);
    vec_t r;
    r.en = en; r.pc = pc; r.upd = upd; r.fill_pc = fpc; r.data = d;
    r.exp_ready = rdy_e; r.exp_valid = v; r.exp_inst = inst; r.exp_pc = vpc;
    r.exp_upd = u; r.exp_mem_pc = mpc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic fl, input logic en,
                       input logic [31:0] pc, input logic upd, input logic [31:0] fpc,
                       input logic [31:0] data);
    rst_in              = rst;
    rdy_in              = rdy;
    flush               = fl;
    bus.if2cache_en     = en;
    bus.if2cache_PC     = pc;
    bus.mem2cache_upd   = upd;
    bus.mem2cache_PC    = fpc;
    bus.mem2cache_idx   = fpc[4:1];
    bus.mem2cache_tag   = fpc[31:5];
    bus.mem2if_inst_out = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ready(input string name, input logic exp);
    #1;
    chk(name, 32'(bus.cache2if_ready), 32'(exp));
  endtask

  task automatic check_outs(input string name, input logic v, input logic [31:0] inst,
                            input logic [31:0] pc, input logic u, input logic [31:0] mpc);
    chk({name, ".valid"}, 32'(bus.cache2if_valid), 32'(v));
    chk({name, ".inst"}, bus.cache2if_inst, v ? inst : 32'h0);
    chk({name, ".pc"}, bus.cache2if_PC, v ? pc : 32'h0);
    chk({name, ".upd_en"}, 32'(bus.cache2mem_upd_en), 32'(u));
    if (u) chk({name, ".mem_pc"}, bus.cache2mem_PC, mpc);
  endtask

  // ---------------- reference model (word-level) ----------------
  bit          m_vld  [16];
  logic [26:0] m_tag  [16];
  logic [31:0] m_data [16];
  bit          m_wait, m_resp;
  logic [31:0] m_miss_pc;
  logic        e_valid, e_upd;
  logic [31:0] e_inst, e_pc, e_mpc;

  function automatic logic [31:0] memfn(logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
    m_wait = 0; m_resp = 0;
    e_valid = 0; e_inst = 0; e_pc = 0; e_upd = 0; e_mpc = 0;
  endtask

  // Outcome of one clock edge given the inputs currently driven.
  task automatic model_edge(input logic rst, input logic rdy, input logic fl, input logic en,
                            input logic [31:0] pc, input logic upd, input logic [31:0] fpc,
                            input logic [31:0] data);
    int          ri, fi;
    bit          hit, accept;
    logic [31:0] hit_word;
    if (rst) begin
      model_reset();
      return;
    end
    if (!rdy) return;
    ri       = int'(pc[4:1]);
    fi       = int'(fpc[4:1]);
    hit      = m_vld[ri] && (m_tag[ri] == pc[31:5]);
    hit_word = m_data[ri];
    accept   = !m_wait && !m_resp && !fl && en;
    if (upd) begin
      m_vld[fi] = 1'b1; m_tag[fi] = fpc[31:5]; m_data[fi] = data;
    end
    e_valid = 0; e_inst = 0; e_pc = 0;
    if (fl) begin
      m_wait = 0; m_resp = 0; e_upd = 0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_wait) begin
      if (upd) begin
        m_wait = 0; m_resp = 1; e_upd = 0;
        e_valid = 1; e_inst = data; e_pc = m_miss_pc;
      end
    end else if (accept) begin
      if (hit) begin
        e_valid = 1; e_inst = hit_word; e_pc = pc;
      end else begin
        m_wait = 1; m_miss_pc = pc; e_upd = 1; e_mpc = pc;
      end
    end
  endtask

  logic [31:0] pool [8];

  initial begin
    logic        r_rst, r_rdy, r_fl, r_en, r_upd;
    logic [31:0] r_pc, r_fpc;

    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Reset state
    tick();
    tick();
    check_outs("reset", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("reset.mem_pc", bus.cache2mem_PC, 32'h0);

    // Directed table: cold miss, hit, conflict misses, back-to-back hits
    tbl.push_back(mk(1, 32'h00, 0, 32'h00, 32'h0,        1, 0, 32'h0,        32'h00, 1, 32'h00));
    tbl.push_back(mk(1, 32'h00, 0, 32'h00, 32'h0,        0, 0, 32'h0,        32'h00, 1, 32'h00));
    tbl.push_back(mk(0, 32'h00, 1, 32'h00, 32'h0000_0513, 0, 1, 32'h0000_0513, 32'h00, 0, 32'h00));
    tbl.push_back(mk(0, 32'h00, 0, 32'h00, 32'h0,        0, 0, 32'h0,        32'h00, 0, 32'h00));
    tbl.push_back(mk(1, 32'h00, 0, 32'h00, 32'h0,        1, 1, 32'h0000_0513, 32'h00, 0, 32'h00));
    tbl.push_back(mk(1, 32'h04, 0, 32'h00, 32'h0,        1, 0, 32'h0,        32'h00, 1, 32'h04));
    tbl.push_back(mk(0, 32'h00, 1, 32'h04, 32'h0040_0093, 0, 1, 32'h0040_0093, 32'h04, 0, 32'h00));
    tbl.push_back(mk(0, 32'h00, 0, 32'h00, 32'h0,        0, 0, 32'h0,        32'h00, 0, 32'h00));
    tbl.push_back(mk(1, 32'h24, 0, 32'h00, 32'h0,        1, 0, 32'h0,        32'h00, 1, 32'h24));
    tbl.push_back(mk(0, 32'h00, 1, 32'h24, 32'h0240_0113, 0, 1, 32'h0240_0113, 32'h24, 0, 32'h00));
    tbl.push_back(mk(0, 32'h00, 0, 32'h00, 32'h0,        0, 0, 32'h0,        32'h00, 0, 32'h00));
    tbl.push_back(mk(1, 32'h04, 0, 32'h00, 32'h0,        1, 0, 32'h0,        32'h00, 1, 32'h04));
    tbl.push_back(mk(0, 32'h00, 1, 32'h04, 32'h0040_0093, 0, 1, 32'h0040_0093, 32'h04, 0, 32'h00));
    tbl.push_back(mk(0, 32'h00, 0, 32'h00, 32'h0,        0, 0, 32'h0,        32'h00, 0, 32'h00));
    tbl.push_back(mk(1, 32'h00, 0, 32'h00, 32'h0,        1, 1, 32'h0000_0513, 32'h00, 0, 32'h00));
    tbl.push_back(mk(1, 32'h04, 0, 32'h00, 32'h0,        1, 1, 32'h0040_0093, 32'h04, 0, 32'h00));

    foreach (tbl[i]) begin
      drive(1'b0, 1'b1, 1'b0, tbl[i].en, tbl[i].pc, tbl[i].upd, tbl[i].fill_pc, tbl[i].data);
      check_ready($sformatf("tbl%0d.ready", i), tbl[i].exp_ready);
      tick();
      check_outs($sformatf("tbl%0d", i), tbl[i].exp_valid, tbl[i].exp_inst, tbl[i].exp_pc,
                 tbl[i].exp_upd, tbl[i].exp_mem_pc);
    end

    // Flush during MISS, then a late fill writes the entry silently
    drive(0, 1, 0, 1, 32'h100, 0, 32'h0, 32'h0);
    check_ready("fl.ready0", 1'b1);
    tick(); check_outs("fl.acc", 0, 0, 0, 1, 32'h100);
    tick(); check_outs("fl.wait", 0, 0, 0, 1, 32'h100);
    drive(0, 1, 1, 1, 32'h100, 0, 32'h0, 32'h0);
    check_ready("fl.ready_flush", 1'b0);
    tick(); check_outs("fl.flushed", 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    check_ready("fl.ready_after", 1'b1);
    tick(); check_outs("fl.idle", 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 32'h0, 1, 32'h100, 32'h0FF0_0093);
    tick(); check_outs("fl.late_fill", 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 32'h100, 0, 32'h0, 32'h0);
    check_ready("fl.ready_hit", 1'b1);
    tick(); check_outs("fl.hit", 1, 32'h0FF0_0093, 32'h100, 0, 0);

    // Stall during RESP: response held, then released once
    drive(0, 1, 0, 1, 32'h40, 0, 32'h0, 32'h0);
    tick(); check_outs("st.miss", 0, 0, 0, 1, 32'h40);
    drive(0, 1, 0, 0, 32'h0, 1, 32'h40, 32'h00A0_0513);
    tick(); check_outs("st.resp", 1, 32'h00A0_0513, 32'h40, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
      check_ready($sformatf("st.ready_stall%0d", k), 1'b0);
      tick(); check_outs($sformatf("st.hold%0d", k), 1, 32'h00A0_0513, 32'h40, 0, 0);
    end
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    check_ready("st.ready_resp", 1'b0);
    tick(); check_outs("st.release", 0, 0, 0, 0, 0);
    check_ready("st.ready_idle", 1'b1);
    tick(); check_outs("st.idle", 0, 0, 0, 0, 0);

    // Reset mid-MISS, with flush high and rdy_in low to show reset wins
    drive(0, 1, 0, 1, 32'h80, 0, 32'h0, 32'h0);
    tick(); check_outs("rm.miss", 0, 0, 0, 1, 32'h80);
    drive(1, 0, 1, 1, 32'h80, 0, 32'h0, 32'h0);
    tick(); check_outs("rm.reset", 0, 0, 0, 0, 0);
    chk("rm.reset.mem_pc", bus.cache2mem_PC, 32'h0);
    drive(0, 1, 0, 1, 32'h0, 0, 32'h0, 32'h0);
    check_ready("rm.ready", 1'b1);
    tick(); check_outs("rm.cold", 0, 0, 0, 1, 32'h0);
    drive(0, 1, 0, 0, 32'h0, 1, 32'h0, 32'h0000_0513);
    tick(); check_outs("rm.fill", 1, 32'h0000_0513, 32'h0, 0, 0);

    // Randomized run against the reference model
    pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0004; pool[2] = 32'h0000_0024;
    pool[3] = 32'h0000_0100; pool[4] = 32'h0000_0044; pool[5] = 32'h0000_03FE;
    pool[6] = 32'h0000_1002; pool[7] = 32'hFFFF_FFFE;
    drive(1, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    tick();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_rdy = ($urandom_range(0, 7) != 0);
      r_fl  = ($urandom_range(0, 24) == 0);
      r_en  = 1'($urandom_range(0, 1));
      r_pc  = pool[$urandom_range(0, 7)];
      r_upd = 1'b0;
      r_fpc = 32'h0;
      if (e_upd && $urandom_range(0, 2) == 0) begin
        r_upd = 1'b1; r_fpc = e_mpc;
      end else if ($urandom_range(0, 39) == 0) begin
        r_upd = 1'b1; r_fpc = pool[$urandom_range(0, 7)];
      end
      drive(r_rst, r_rdy, r_fl, r_en, r_pc, r_upd, r_fpc, memfn(r_fpc));
      check_ready("rand.ready", !m_wait && !m_resp && !r_fl && r_rdy);
      model_edge(r_rst, r_rdy, r_fl, r_en, r_pc, r_upd, r_fpc, memfn(r_fpc));
      tick();
      check_outs("rand", e_valid, e_inst, e_pc, e_upd, e_mpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
